db15_joy_scanner: RTL
=====================

DB15_JOY_SCANNER -- requirements
Module: db15_joy_scanner

Interface
REQ-001 SHALL have parameter DIV, default 32: clk cycles per half-period tick of JOY_CLK; legal range 4..1023.
REQ-002 SHALL have parameter GAP, default 256: idle ticks between scan frames; legal range 1..4095.
REQ-003 SHALL have port clk, input, 1: sole clock, 40-50 MHz (CLK_JOY domain).
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port JOY_DATA, input, 1: serial data from the external shift-register chain; low means pressed.
REQ-006 SHALL have port JOY_CLK, output, 1: shift clock to the chain; the chain shifts on the rising edge.
REQ-007 SHALL have port JOY_LOAD, output, 1: active-low parallel load to the chain.
REQ-008 SHALL have port joystick1, output, 16: player 1 buttons, active-high, bit 0 = R.
REQ-009 SHALL have port joystick2, output, 16: player 2 buttons, active-high.
REQ-010 SHALL have port frame_strobe, output, 1: one-clk pulse on each output update.
REQ-011 SHALL have port present, output, 1: high when a controller chain is detected.

Function
REQ-012 SHALL pass JOY_DATA through a 2-FF synchroniser before any use.
REQ-013 SHALL generate tick as a one-clk pulse every DIV clk cycles from a free-running divider cleared by reset.
REQ-014 SHALL implement the FSM states IDLE, LOAD, LATCH, SHIFT_LO, SHIFT_HI, CHECK and GAP; every state transition occurs only on tick.
REQ-015 IDLE SHALL move to LOAD on the first tick after reset.
REQ-016 In LOAD, JOY_LOAD SHALL be 0 for exactly 1 tick; then -> LATCH.
REQ-017 In LATCH, JOY_LOAD SHALL be 1 for 1 tick; then -> SHIFT_LO with the 5-bit bit counter at 0.
REQ-018 In SHIFT_LO, JOY_CLK SHALL be 0; on the exiting tick, the inverted synchronised data is stored to shift[bit_cnt]; then -> SHIFT_HI.
REQ-019 In SHIFT_HI, JOY_CLK SHALL be 1; on the exiting tick, if bit_cnt=31 -> CHECK, else bit_cnt+1 and -> SHIFT_LO.
REQ-020 Bits 0..15 SHALL map to player 1 and bits 16..31 to player 2, in shift order.
REQ-021 CHECK SHALL last 1 tick and compare the 32-bit frame with the previous frame register.
REQ-022 In CHECK, if the frame equals the previous frame, the outputs SHALL update as in REQ-024..REQ-026 with frame_strobe=1 for 1 clk.
REQ-023 In CHECK, if the frames differ, the outputs SHALL hold and frame_strobe SHALL stay 0 (2-frame debounce); in both cases the previous frame is overwritten with the current frame.
REQ-024 If the accepted frame is all-ones (data stuck low or chain absent with pulldown), present SHALL be 0 and joystick1 and joystick2 SHALL be 0.
REQ-025 Otherwise present SHALL be 1, joystick1 = frame[15:0] and joystick2 = frame[31:16].
REQ-026 All-zero frames (pulled-up input, nothing pressed) SHALL be accepted with present=1.
REQ-027 GAP SHALL count GAP ticks with JOY_CLK=0 and JOY_LOAD=1, then -> LOAD.
REQ-028 Frame period SHALL be exactly (3 + 64 + GAP) ticks.
REQ-029 Outputs SHALL be registered and glitch-free.
REQ-030 JOY_CLK SHALL never be 1 while JOY_LOAD=0.

Reset
REQ-031 On reset_n=0, state SHALL be IDLE, the divider and counters 0, and the shift and previous frames all-ones.
REQ-032 On reset_n=0, JOY_CLK SHALL be 0, JOY_LOAD 1, joystick1 and joystick2 0x0000, frame_strobe 0 and present 0.
REQ-033 Reset asserted mid-SHIFT SHALL abort the frame immediately with no output update.
REQ-034 After reset release, at least two full frames SHALL elapse before the first frame_strobe.

Verification
REQ-035 Bench SHALL use DIV=4, GAP=4 and a chain model with A=16'h0005, B=16'h8001 (active-low on wire) -> after frame 2, joystick1=0x0005, joystick2=0x8001, present=1 and one frame_strobe.
REQ-036 Bench SHALL tie JOY_DATA=1 -> joystick1 and joystick2 = 0x0000, present=1, and frame_strobe every frame from frame 2.
REQ-037 Bench SHALL tie JOY_DATA=0 -> present=0 and joystick1 and joystick2 = 0 with no nonzero output ever.
REQ-038 Bench SHALL change the chain pattern every frame -> no frame_strobe and the outputs hold the last stable value.
REQ-039 Bench SHALL pulse reset_n low during bit 17 -> outputs 0 within 1 clk, JOY_LOAD=1, and the scan restarts from LOAD.
REQ-040 Bench SHALL check that the period between JOY_LOAD falling edges is (67+GAP)*DIV clk and that 32 JOY_CLK rising edges occur per frame.

Source files
------------

// File: rtl/db15_joy_scanner.sv
// Scans a DB15 dual-joystick shift-register chain: load, shift out 32 bits, then
// publish the frame only when two consecutive scans agree.
module db15_joy_scanner #(
  parameter int DIV = 32,
  parameter int GAP = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_strobe,
  output logic        present
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_LATCH    = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_SHIFT_HI = 3'd4;
  localparam logic [2:0] S_CHECK    = 3'd5;
  localparam logic [2:0] S_GAP      = 3'd6;

  localparam logic [9:0]  DIV_LAST = 10'(DIV - 1);
  localparam logic [11:0] GAP_LAST = 12'(GAP - 1);

  logic        data_meta_q, data_meta_d;
  logic        data_sync_q, data_sync_d;
  logic [9:0]  div_cnt_q, div_cnt_d;
  logic [2:0]  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] prev_q, prev_d;
  logic        primed_q, primed_d;
  logic        joy_clk_q, joy_clk_d;
  logic        joy_load_q, joy_load_d;
  logic [15:0] joy1_q, joy1_d;
  logic [15:0] joy2_q, joy2_d;
  logic        strobe_q, strobe_d;
  logic        present_q, present_d;
  logic        tick;
  logic        frame_match;

  assign tick = (div_cnt_q == DIV_LAST);
  // primed_q blocks acceptance until one full frame has been captured as reference
  assign frame_match = primed_q && (shift_q == prev_q);

  always_comb begin
    data_meta_d = JOY_DATA;
    data_sync_d = data_meta_q;
    div_cnt_d   = tick ? 10'd0 : div_cnt_q + 10'd1;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shift_d     = shift_q;
    prev_d      = prev_q;
    primed_d    = primed_q;
    joy1_d      = joy1_q;
    joy2_d      = joy2_q;
    strobe_d    = 1'b0;
    present_d   = present_q;

    if (tick) begin
      case (state_q)
        S_IDLE:  state_d = S_LOAD;
        S_LOAD:  state_d = S_LATCH;
        S_LATCH: begin
          bit_cnt_d = 5'd0;
          state_d   = S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          shift_d[bit_cnt_q] = ~data_sync_q;
          state_d            = S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          if (bit_cnt_q == 5'd31) begin
            state_d = S_CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = S_SHIFT_LO;
          end
        end
        S_CHECK: begin
          if (frame_match) begin
            strobe_d = 1'b1;
            if (&shift_q) begin
              present_d = 1'b0;
              joy1_d    = 16'h0000;
              joy2_d    = 16'h0000;
            end else begin
              present_d = 1'b1;
              joy1_d    = shift_q[15:0];
              joy2_d    = shift_q[31:16];
            end
          end
          prev_d    = shift_q;
          primed_d  = 1'b1;
          gap_cnt_d = 12'd0;
          state_d   = S_GAP;
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) state_d = S_LOAD;
          else gap_cnt_d = gap_cnt_q + 12'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Pins are decoded from the next state so they register in step with state_q
    joy_clk_d  = (state_d == S_SHIFT_HI);
    joy_load_d = (state_d != S_LOAD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      div_cnt_q   <= 10'd0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 5'd0;
      gap_cnt_q   <= 12'd0;
      shift_q     <= '1;
      prev_q      <= '1;
      primed_q    <= 1'b0;
      joy_clk_q   <= 1'b0;
      joy_load_q  <= 1'b1;
      joy1_q      <= 16'h0000;
      joy2_q      <= 16'h0000;
      strobe_q    <= 1'b0;
      present_q   <= 1'b0;
    end else begin
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shift_q     <= shift_d;
      prev_q      <= prev_d;
      primed_q    <= primed_d;
      joy_clk_q   <= joy_clk_d;
      joy_load_q  <= joy_load_d;
      joy1_q      <= joy1_d;
      joy2_q      <= joy2_d;
      strobe_q    <= strobe_d;
      present_q   <= present_d;
    end
  end

  assign JOY_CLK      = joy_clk_q;
  assign JOY_LOAD     = joy_load_q;
  assign joystick1    = joy1_q;
  assign joystick2    = joy2_q;
  assign frame_strobe = strobe_q;
  assign present      = present_q;

endmodule
